// File: rtl/cache_pkg.sv
// Shared cache types: fetch command encoding, refill FSM states, status encodings.
// Optional macro LINE_FETCH_WB_EN adds the victim writeback states.
package cache_pkg;

  typedef enum logic [1:0] {
    FETCH_NONE    = 2'b00,
    FETCH_LINE    = 2'b01,
    FETCH_WB_LINE = 2'b10,
    FETCH_RSVD    = 2'b11
  } fetch_cmd_t;

  // Encodings are fixed so both builds share the same state register layout.
  typedef enum logic [2:0] {
    StIdle     = 3'd0,
`ifdef LINE_FETCH_WB_EN
    StWbAddr   = 3'd1,
    StWbRd     = 3'd2,
    StWbData   = 3'd3,
`endif
    StFillAddr = 3'd4,
    StFillData = 3'd5,
    StDone     = 3'd6
  } line_fetch_state_t;

  typedef enum logic [1:0] {
    ProcIdle = 2'b00,
    ProcBusy = 2'b01,
    ProcDone = 2'b10,
    ProcErr  = 2'b11
  } proc_status_t;

  typedef enum logic [1:0] {
    AccHit   = 2'b00,
    AccMiss  = 2'b01,
    AccFill  = 2'b10,
    AccEvict = 2'b11
  } acc_status_t;

endpackage

// File: rtl/fetch_beat_cnt.sv
// Beat counter for line bursts: clear has priority, increment wraps at 2**Width.
module fetch_beat_cnt #(
  parameter int unsigned Width = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [Width-1:0] cnt_o,
  output logic             last_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  // Next count: clear wins over increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + Width'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  // Line length is a power of two, so the last beat is all ones.
  assign last_o = &cnt_q;

endmodule

// File: rtl/line_fetch_ctrl.sv
// Line refill engine: optional victim writeback, then burst fill of one cache line.
// Macro LINE_FETCH_WB_EN enables the writeback path; without it cmd 10 acts as cmd 01.
module line_fetch_ctrl
  import cache_pkg::*;
#(
  parameter int unsigned addr_width = 32,
  parameter int unsigned list_depth = 4,
  parameter int unsigned data_width = 32,
  parameter int unsigned list_width = 32,
  localparam int unsigned TW = $clog2(list_depth),
  localparam int unsigned OW = $clog2(list_width)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fetch_req,
  output logic                  fetch_gnt,
  input  logic [1:0]            fetch_cmd,
  input  logic [TW-1:0]         fetch_tag,
  input  logic [addr_width-1:0] fetch_addr,
  input  logic [addr_width-1:0] fetch_evict_addr,
  output logic                  fetch_done,
  output logic                  mem_ren,
  output logic [TW+OW-1:0]      mem_raddr,
  input  logic [data_width-1:0] mem_rdata,
  output logic                  mem_wen,
  output logic [TW+OW-1:0]      mem_waddr,
  output logic [data_width-1:0] mem_wdata,
  input  logic                  mem_wready,
  output logic                  bus_req,
  output logic                  bus_we,
  output logic [addr_width-1:0] bus_addr,
  input  logic                  bus_gnt,
  output logic                  bus_wvalid,
  output logic [data_width-1:0] bus_wdata,
  input  logic                  bus_wready,
  input  logic                  bus_rvalid,
  input  logic [data_width-1:0] bus_rdata,
  output logic                  bus_rready
);

  line_fetch_state_t     state_q, state_d;
  logic [TW-1:0]         tag_q;
  logic [addr_width-1:0] addr_q;
  logic                  fetch_done_q;
  logic                  hs;
  logic                  cnt_clr, cnt_inc, cnt_last;
  logic [OW-1:0]         cnt;

  assign hs = (state_q == StIdle) && fetch_req;

`ifdef LINE_FETCH_WB_EN
  logic [addr_width-1:0] evict_q;
  logic [data_width-1:0] word_q;
  logic                  wb_first_q;
`else
  logic unused_wb;
  assign unused_wb = ^{fetch_evict_addr, mem_rdata, bus_wready};
`endif

  fetch_beat_cnt #(
    .Width (OW)
  ) u_beat_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (cnt_clr),
    .inc_i  (cnt_inc),
    .cnt_o  (cnt),
    .last_o (cnt_last)
  );

  // Next state and all outputs decoded from the current state.
  always_comb begin
    state_d    = state_q;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    fetch_gnt  = 1'b0;
    mem_ren    = 1'b0;
    mem_raddr  = '0;
    mem_wen    = 1'b0;
    mem_waddr  = '0;
    mem_wdata  = '0;
    bus_req    = 1'b0;
    bus_we     = 1'b0;
    bus_addr   = '0;
    bus_wvalid = 1'b0;
    bus_wdata  = '0;
    bus_rready = 1'b0;
    unique case (state_q)
      StIdle: begin
        fetch_gnt = fetch_req;
        if (fetch_req) begin
          cnt_clr = 1'b1;
          case (fetch_cmd_t'(fetch_cmd))
            FETCH_LINE:    state_d = StFillAddr;
`ifdef LINE_FETCH_WB_EN
            FETCH_WB_LINE: state_d = StWbAddr;
`else
            FETCH_WB_LINE: state_d = StFillAddr;
`endif
            default:       state_d = StDone;
          endcase
        end
      end
`ifdef LINE_FETCH_WB_EN
      StWbAddr: begin
        bus_req  = 1'b1;
        bus_we   = 1'b1;
        bus_addr = evict_q;
        if (bus_gnt) state_d = StWbRd;
      end
      StWbRd: begin
        mem_ren   = 1'b1;
        mem_raddr = {tag_q, cnt};
        state_d   = StWbData;
      end
      StWbData: begin
        bus_wvalid = 1'b1;
        // Read data is only valid in the first cycle; hold it from word_q afterwards.
        bus_wdata  = wb_first_q ? mem_rdata : word_q;
        if (bus_wready) begin
          if (cnt_last) begin
            cnt_clr = 1'b1;
            state_d = StFillAddr;
          end else begin
            cnt_inc = 1'b1;
            state_d = StWbRd;
          end
        end
      end
`endif
      StFillAddr: begin
        bus_req  = 1'b1;
        bus_addr = addr_q;
        if (bus_gnt) state_d = StFillData;
      end
      StFillData: begin
        bus_rready = mem_wready;
        mem_wen    = bus_rvalid;
        mem_waddr  = {tag_q, cnt};
        mem_wdata  = bus_rdata;
        if (bus_rvalid && mem_wready) begin
          cnt_inc = 1'b1;
          if (cnt_last) state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State, request latches and the registered completion pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      tag_q        <= '0;
      addr_q       <= '0;
      fetch_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_done_q <= (state_d == StDone);
      if (hs) begin
        tag_q  <= fetch_tag;
        addr_q <= fetch_addr;
      end
    end
  end

`ifdef LINE_FETCH_WB_EN
  // Victim address latch and writeback word holding register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evict_q    <= '0;
      word_q     <= '0;
      wb_first_q <= 1'b0;
    end else begin
      wb_first_q <= (state_q == StWbRd);
      if (hs) evict_q <= fetch_evict_addr;
      if (state_q == StWbData && wb_first_q) word_q <= mem_rdata;
    end
  end
`endif

  assign fetch_done = fetch_done_q;

endmodule

// File: doc/line_fetch_ctrl.md
# line_fetch_ctrl

Line refill/eviction engine sitting directly downstream of the cache read/write controllers' fetch port. Accepts one fetch request at a time (`fetch_req`/`fetch_gnt`), optionally writes the victim line back to the external bus, then bursts the new line from the bus into the cache data memory under the requested tag, and pulses `fetch_done`. Owns the refill path only; hit-path writes stay with the controllers.

## Interface
- `addr_width`, 32, byte/word address width
- `list_depth`, 4, number of cache lines; `TW = $clog2(list_depth)`
- `data_width`, 32, word width
- `list_width`, 32, words per line; `OW = $clog2(list_width)`, power of two ≥2
- `clk` in 1: clock
- `rst_n` in 1: reset, asynchronous, active-low
- `fetch_req` in 1: fetch request from controller, held until granted
- `fetch_gnt` out 1: request accepted (combinational)
- `fetch_cmd` in 2: 00 none, 01 fetch line, 10 write back victim then fetch, 11 reserved (treated as 00)
- `fetch_tag` in TW: destination line slot
- `fetch_addr` in addr_width: line-aligned fill address
- `fetch_evict_addr` in addr_width: line-aligned victim address (used for cmd 10)
- `fetch_done` out 1: one-cycle completion pulse, registered
- `mem_ren` out 1 / `mem_raddr` out TW+OW / `mem_rdata` in data_width: data-mem read, fixed 1-cycle latency, always ready
- `mem_wen` out 1 / `mem_waddr` out TW+OW / `mem_wdata` out data_width / `mem_wready` in 1: data-mem write port
- `bus_req` out 1 / `bus_we` out 1 / `bus_addr` out addr_width / `bus_gnt` in 1: burst address phase, burst length = list_width
- `bus_wvalid` out 1 / `bus_wdata` out data_width / `bus_wready` in 1: writeback data
- `bus_rvalid` in 1 / `bus_rdata` in data_width / `bus_rready` out 1: fill data

## Operation
- States: IDLE, WB_ADDR, WB_RD, WB_DATA, FILL_ADDR, FILL_DATA, DONE.
- IDLE: `fetch_gnt = fetch_req`. On handshake latch cmd, tag, addr, evict_addr; clear beat counter. cmd 10 → WB_ADDR; 01 → FILL_ADDR; 00/11 → DONE.
- WB_ADDR: `bus_req=1, bus_we=1, bus_addr=evict_addr`; on `bus_gnt` → WB_RD.
- WB_RD: `mem_ren=1, mem_raddr={tag,cnt}` → WB_DATA.
- WB_DATA: capture `mem_rdata` into word register on entry; `bus_wvalid=1`; on `bus_wready`: last beat (cnt==list_width-1) → FILL_ADDR and cnt←0, else cnt++ → WB_RD.
- FILL_ADDR: `bus_req=1, bus_we=0, bus_addr=fetch_addr`; on `bus_gnt` → FILL_DATA.
- FILL_DATA: `bus_rready=mem_wready`; `mem_wen=bus_rvalid`, `mem_waddr={tag,cnt}`, `mem_wdata=bus_rdata`; each beat with `bus_rvalid&&mem_wready` increments cnt; last beat → DONE.
- DONE: `fetch_done=1` for one cycle → IDLE. No new grant while in DONE.
- Counter OW bits, wraps to 0 after last beat; never exceeds list_width-1.

## Timing
- Reset: state IDLE, counter 0, all latches 0, every output 0 (`fetch_gnt` 0 since IDLE with `fetch_req` low).
- cmd 01, handshake at cycle T, zero-wait bus: `bus_req` T+1 with `bus_gnt`; beats T+2..T+1+list_width; `fetch_done` at T+2+list_width.
- cmd 10 adds 1 address cycle + 2 cycles per writeback word minimum.
- cmd 00/11: `fetch_done` at T+1, no bus or mem activity.
- `bus_rvalid` while `mem_wready` low: beat not consumed, `bus_rready` 0, data must be held by bus.
- `bus_wready` low: `bus_wdata` stable from word register.
- `fetch_req` while busy: `fetch_gnt` 0 until back in IDLE.
- Async reset mid-burst: immediate return to IDLE, partial line content undefined, no `fetch_done`; bus and controllers are reset concurrently.

## Configuration
- `LINE_FETCH_WB_EN` defined: full writeback path as above.
- Undefined: WB_* states, word register and `fetch_evict_addr` use compiled out; cmd 10 treated as 01; `mem_ren`, `bus_we`, `bus_wvalid` tied 0.

## Structure
- `cache_pkg`: `fetch_cmd_t` (FETCH_NONE=00, FETCH_LINE=01, FETCH_WB_LINE=10, FETCH_RSVD=11), `line_fetch_state_t`, shared proc/acc status encodings.
- Sub-module `fetch_beat_cnt`: OW-bit counter with clear, increment, `last` flag.

## Test plan
- cmd 01, tag 2, addr 0x100, zero-wait bus → 32 `mem_wen` at waddr 64..95 with bus data, `fetch_done` at T+34.
- cmd 10, evict 0x200, tag 1 preloaded 0xA0..0xBF → bus writes 32 words 0xA0..0xBF to 0x200, then fill of `fetch_addr`, single `fetch_done`.
- Fill with `mem_wready` low every other cycle → `bus_rready` follows, no beat lost or duplicated, 32 writes in order.
- cmd 00 and 11 → `fetch_done` at T+1, `bus_req`/`mem_wen` never asserted.
- Second `fetch_req` held during fill → `fetch_gnt` only in cycle after `fetch_done`.
- `rst_n` low at beat 10 → all outputs 0 same cycle, IDLE; new request after release completes normally.
